// File: rtl/dfp_line_responder_if.sv
// Downward-facing port bundle between a cache (master) and its line-level
// backing store (slave).
//   dfp_addr   : line byte address
//   dfp_read   : line read request, held until the response cycle
//   dfp_write  : line write request, held until the response cycle
//   dfp_wdata  : write line data
//   dfp_rdata  : read line data, valid while dfp_resp is high for a read
//   dfp_resp   : single-cycle completion pulse
interface dfp_line_responder_if #(
    parameter int unsigned LINE_BITS = 256
);
    logic [31:0]          dfp_addr;
    logic                 dfp_read;
    logic                 dfp_write;
    logic [LINE_BITS-1:0] dfp_wdata;
    logic [LINE_BITS-1:0] dfp_rdata;
    logic                 dfp_resp;

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  dfp_rdata, dfp_resp
    );

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output dfp_rdata, dfp_resp
    );
endinterface

// File: rtl/dfp_line_responder.sv
// Memory-side responder for a cache's downward-facing port. Accepts one line
// read/write at a time, answers with a one-cycle dfp_resp after a fixed
// per-op latency, keeps a small line-addressed store, flags protocol
// violations and counts completed traffic.
//   clk       : clock, all state on rising edge
//   rst       : asynchronous active-low reset
//   dfp       : slave side of the line port (addr/read/write/wdata in,
//               rdata/resp out)
//   rd_count  : completed reads (wraps)
//   wr_count  : completed writes (wraps)
//   proto_err : sticky protocol-violation flag, cleared only by reset
module dfp_line_responder #(
    parameter int unsigned LINE_BITS     = 256,
    parameter int unsigned OFFSET_BITS   = 5,
    parameter int unsigned INDEX_BITS    = 6,
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 4,
    parameter int unsigned CNT_BITS      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    dfp_line_responder_if.slave    dfp,
    output logic [CNT_BITS-1:0]    rd_count,
    output logic [CNT_BITS-1:0]    wr_count,
    output logic                   proto_err
);

    localparam int unsigned DEPTH   = 2 ** INDEX_BITS;
    localparam int unsigned IDX_LO  = OFFSET_BITS;
    localparam int unsigned IDX_HI  = OFFSET_BITS + INDEX_BITS - 1;
    localparam int unsigned LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned LAT_W   = $clog2(LAT_MAX + 1);

    localparam logic [LAT_W-1:0] RD_LOAD = LAT_W'(READ_LATENCY - 1);
    localparam logic [LAT_W-1:0] WR_LOAD = LAT_W'(WRITE_LATENCY - 1);
    localparam logic             RD_DIRECT = (READ_LATENCY <= 1);
    localparam logic             WR_DIRECT = (WRITE_LATENCY <= 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 op_wr_q, op_wr_d;
    logic [31:0]          addr_q, addr_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic [LAT_W-1:0]     cnt_q, cnt_d;
    logic                 resp_q, resp_d;
    logic [LINE_BITS-1:0] rdata_q, rdata_d;
    logic [CNT_BITS-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_BITS-1:0]  wr_cnt_q, wr_cnt_d;
    logic                 perr_q, perr_d;
    logic [LINE_BITS-1:0] mem_q [DEPTH];

    logic                  mem_we_c;
    logic [INDEX_BITS-1:0] wr_idx_c;
    logic [INDEX_BITS-1:0] rd_idx_c;

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            resp_q   <= 1'b0;
            rdata_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_wr_q  <= op_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            resp_q   <= resp_d;
            rdata_q  <= rdata_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            perr_q   <= perr_d;
        end
    end

    // Line store; write commits on the edge that ends the response cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we_c) begin
            mem_q[wr_idx_c] <= wdata_q;
        end
    end

    // Next-state, capture, checking and counter logic
    always_comb begin
        state_d  = state_q;
        op_wr_d  = op_wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        perr_d   = perr_q;
        rdata_d  = rdata_q;
        resp_d   = 1'b0;
        mem_we_c = 1'b0;
        wr_idx_c = addr_q[IDX_HI:IDX_LO];

        case (state_q)
            S_IDLE: begin
                if (dfp.dfp_read || dfp.dfp_write) begin
                    // read and write together is resolved as a write
                    op_wr_d = dfp.dfp_write;
                    addr_d  = dfp.dfp_addr;
                    wdata_d = dfp.dfp_wdata;
                    if (dfp.dfp_read && dfp.dfp_write) begin
                        perr_d = 1'b1;
                    end
                    if (dfp.dfp_write) begin
                        cnt_d   = WR_LOAD;
                        state_d = WR_DIRECT ? S_RESP : S_BUSY;
                    end else begin
                        cnt_d   = RD_LOAD;
                        state_d = RD_DIRECT ? S_RESP : S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                // requester must hold its request line and address until resp
                if ((op_wr_q ? !dfp.dfp_write : !dfp.dfp_read) || (dfp.dfp_addr != addr_q)) begin
                    perr_d = 1'b1;
                end
                if (cnt_q == LAT_W'(1)) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (op_wr_q) begin
                    mem_we_c = 1'b1;
                    wr_cnt_d = wr_cnt_q + CNT_BITS'(1);
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_BITS'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Response and read data are registered on entry to RESP
        rd_idx_c = addr_d[IDX_HI:IDX_LO];
        if (state_d == S_RESP) begin
            resp_d = 1'b1;
            if (!op_wr_d) begin
                rdata_d = mem_q[rd_idx_c];
            end
        end
    end

    assign dfp.dfp_resp  = resp_q;
    assign dfp.dfp_rdata = rdata_q;
    assign rd_count      = rd_cnt_q;
    assign wr_count      = wr_cnt_q;
    assign proto_err     = perr_q;

endmodule

// File: tb/tb_dfp_line_responder.sv
// Bench for dfp_line_responder: a transaction-level model (line array,
// counters, expected response cycle) checked every cycle, plus literal
// expectations on latency, data and counters. Two instances cover the
// 4/4-cycle and 1/7-cycle latency configurations.
module tb_dfp_line_responder;

    localparam int unsigned LB = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          sel;
    logic [31:0]   a_s;
    logic          rd_s;
    logic          wr_s;
    logic [LB-1:0] wd_s;

    dfp_line_responder_if #(.LINE_BITS(LB)) ifa ();
    dfp_line_responder_if #(.LINE_BITS(LB)) ifb ();

    assign ifa.dfp_addr  = sel ? 32'd0 : a_s;
    assign ifa.dfp_read  = !sel && rd_s;
    assign ifa.dfp_write = !sel && wr_s;
    assign ifa.dfp_wdata = sel ? '0 : wd_s;
    assign ifb.dfp_addr  = sel ? a_s : 32'd0;
    assign ifb.dfp_read  = sel && rd_s;
    assign ifb.dfp_write = sel && wr_s;
    assign ifb.dfp_wdata = sel ? wd_s : '0;

    logic [15:0] rda, wra;
    logic [3:0]  rdb, wrb;
    logic        pea, peb;

    dfp_line_responder #(
        .LINE_BITS(LB), .OFFSET_BITS(5), .INDEX_BITS(6),
        .READ_LATENCY(4), .WRITE_LATENCY(4), .CNT_BITS(16)
    ) u_dut_a (
        .clk(clk), .rst(rst), .dfp(ifa),
        .rd_count(rda), .wr_count(wra), .proto_err(pea)
    );

    dfp_line_responder #(
        .LINE_BITS(LB), .OFFSET_BITS(5), .INDEX_BITS(6),
        .READ_LATENCY(1), .WRITE_LATENCY(7), .CNT_BITS(4)
    ) u_dut_b (
        .clk(clk), .rst(rst), .dfp(ifb),
        .rd_count(rdb), .wr_count(wrb), .proto_err(peb)
    );

    logic          resp_s;
    logic [LB-1:0] rdata_s;
    logic [15:0]   rdc_s, wrc_s;
    logic          perr_s;
    assign resp_s  = sel ? ifb.dfp_resp  : ifa.dfp_resp;
    assign rdata_s = sel ? ifb.dfp_rdata : ifa.dfp_rdata;
    assign rdc_s   = sel ? 16'(rdb) : rda;
    assign wrc_s   = sel ? 16'(wrb) : wra;
    assign perr_s  = sel ? peb : pea;

    // Transaction-level model
    logic [LB-1:0] mem [64];
    int            rd_cnt, wr_cnt;
    logic [LB-1:0] last_rd;
    int            cyc = 0;
    int            resp_at, perr_at, acc_edge, last_resp_cyc;
    int            rlat, wlat;
    logic [15:0]   cmask;
    bit            cur_wr;
    int            cur_idx;
    logic [LB-1:0] cur_data;
    bit            pend, pend_wr;
    int            pend_cyc, pend_idx;
    logic [LB-1:0] pend_data;
    bit            chk_en;
    int            nvec = 0;
    int            nerr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) mem[i] = '0;
        rd_cnt        = 0;
        wr_cnt        = 0;
        last_rd       = '0;
        resp_at       = -100;
        perr_at       = 32'h3fff_ffff;
        pend          = 1'b0;
        last_resp_cyc = -1000;
    endfunction

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            if (pend && cyc > pend_cyc) begin
                if (pend_wr) begin
                    mem[pend_idx] = pend_data;
                    wr_cnt++;
                end else begin
                    rd_cnt++;
                end
                pend = 1'b0;
            end
            chk("resp", LB'(resp_s), LB'(cyc == resp_at));
            if (resp_s) last_resp_cyc = cyc;
            if (cyc == resp_at) begin
                if (!cur_wr) last_rd = mem[cur_idx];
                pend      = 1'b1;
                pend_cyc  = cyc;
                pend_wr   = cur_wr;
                pend_idx  = cur_idx;
                pend_data = cur_data;
            end
            chk("rdata", rdata_s, last_rd);
            chk("rd_count", LB'(rdc_s), LB'(16'(rd_cnt) & cmask));
            chk("wr_count", LB'(wrc_s), LB'(16'(wr_cnt) & cmask));
            chk("proto_err", LB'(perr_s), LB'(cyc >= perr_at));
        end
    end

    task automatic do_reset(input bit new_sel);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        rd_s = 1'b0;
        wr_s = 1'b0;
        sel  = new_sel;
        if (new_sel) begin
            rlat = 1; wlat = 7; cmask = 16'h000f;
        end else begin
            rlat = 4; wlat = 4; cmask = 16'hffff;
        end
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic start_req(input logic [31:0] a, input bit r, input bit w, input logic [LB-1:0] d);
        a_s  = a;
        rd_s = r;
        wr_s = w;
        wd_s = d;
        acc_edge      = cyc + 1;
        cur_wr        = w;
        cur_idx       = int'(a[10:5]);
        cur_data      = d;
        resp_at       = acc_edge + (w ? wlat : rlat) - 1;
        last_resp_cyc = -1000;
        if (r && w && perr_at > acc_edge) perr_at = acc_edge;
    endtask

    // Hold the request through the response cycle, then release it
    task automatic finish_req(input bit drop, input int exp_lat);
        while (cyc < resp_at + 1) begin
            @(posedge clk);
            #1;
            if (drop && cyc == acc_edge + 1) begin
                rd_s = 1'b0;
                wr_s = 1'b0;
                if (perr_at > acc_edge + 2) perr_at = acc_edge + 2;
            end
        end
        rd_s = 1'b0;
        wr_s = 1'b0;
        chk("latency", LB'(last_resp_cyc - (acc_edge - 1)), LB'(exp_lat));
    endtask

    task automatic txn(input logic [31:0] a, input bit r, input bit w, input logic [LB-1:0] d, input int exp_lat);
        start_req(a, r, w, d);
        finish_req(1'b0, exp_lat);
    endtask

    logic [LB-1:0] dead, lineA, lineB, lineC, lineD;
    int            r1;

    initial begin
        dead  = {8{32'hDEADBEEF}};
        lineA = {8{32'hA5A5_0001}};
        lineB = {8{32'h0B0B_1234}};
        lineC = {8{32'hC0C0_CAFE}};
        lineD = {4{64'h0123_4567_89AB_CDEF}};
        rst = 1'b0; sel = 1'b0; a_s = '0; rd_s = 1'b0; wr_s = 1'b0; wd_s = '0;
        rlat = 4; wlat = 4; cmask = 16'hffff;
        chk_en = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk_en = 1'b1;

        // reset state
        chk("rst_resp", LB'(resp_s), '0);
        chk("rst_rdata", rdata_s, '0);
        chk("rst_perr", LB'(perr_s), '0);

        // read after reset returns zero at +4
        txn(32'h0000_0040, 1'b1, 1'b0, '0, 4);
        chk("rd0_data", rdata_s, '0);
        chk("rd0_count", LB'(rdc_s), LB'(16'd1));
        chk("rd0_perr", LB'(perr_s), '0);

        // write then read back
        txn(32'h0000_0080, 1'b0, 1'b1, dead, 4);
        chk("wr1_count", LB'(wrc_s), LB'(16'd1));
        txn(32'h0000_0080, 1'b1, 1'b0, '0, 4);
        chk("rd_dead", rdata_s, dead);

        // address aliasing on index 1
        txn(32'h0000_0020, 1'b0, 1'b1, lineA, 4);
        txn(32'h0000_0820, 1'b1, 1'b0, '0, 4);
        chk("alias_data", rdata_s, lineA);
        txn(32'h0000_0040, 1'b1, 1'b0, '0, 4);
        chk("idx2_zero", rdata_s, '0);

        // read+write together: write wins, sticky error, reads unchanged
        txn(32'h0000_0060, 1'b1, 1'b1, lineB, 4);
        chk("rw_perr", LB'(perr_s), LB'(1'b1));
        chk("rw_rdcount", LB'(rdc_s), LB'(16'd4));
        chk("rw_wrcount", LB'(wrc_s), LB'(16'd3));
        txn(32'h0000_0060, 1'b1, 1'b0, '0, 4);
        chk("rw_data", rdata_s, lineB);
        chk("rw_perr_sticky", LB'(perr_s), LB'(1'b1));

        // dropped request in BUSY still completes at +4
        do_reset(1'b0);
        chk("rst2_perr", LB'(perr_s), '0);
        start_req(32'h0000_0060, 1'b1, 1'b0, '0);
        finish_req(1'b1, 4);
        chk("drop_perr", LB'(perr_s), LB'(1'b1));
        chk("drop_rdcount", LB'(rdc_s), LB'(16'd1));

        // reset during a write's BUSY aborts it
        start_req(32'h0000_0080, 1'b0, 1'b1, lineC);
        repeat (2) begin @(posedge clk); #1; end
        do_reset(1'b0);
        chk("abort_wr", LB'(wrc_s), '0);
        chk("abort_rd", LB'(rdc_s), '0);
        txn(32'h0000_0080, 1'b1, 1'b0, '0, 4);
        chk("abort_line", rdata_s, '0);

        // READ_LATENCY=1, WRITE_LATENCY=7, 4-bit counters
        do_reset(1'b1);
        txn(32'h0000_0020, 1'b0, 1'b1, lineD, 7);
        txn(32'h0000_0000, 1'b1, 1'b0, '0, 1);
        r1 = last_resp_cyc;
        txn(32'h0000_0020, 1'b1, 1'b0, '0, 1);
        chk("b2b_gap", LB'(last_resp_cyc - r1), LB'(2));
        chk("b2b_data", rdata_s, lineD);
        r1 = last_resp_cyc;
        txn(32'h0000_0040, 1'b1, 1'b0, '0, 1);
        chk("b2b_gap2", LB'(last_resp_cyc - r1), LB'(2));
        chk("b2b_rdcount", LB'(rdc_s), LB'(16'd3));
        for (int i = 2; i <= 15; i++) begin
            txn(32'(i * 32), 1'b0, 1'b1, {8{32'(i)}}, 7);
        end
        chk("wr_pre_wrap", LB'(wrc_s), LB'(16'd15));
        txn(32'h0000_0400, 1'b0, 1'b1, lineA, 7);
        chk("wr_wrap", LB'(wrc_s), '0);
        txn(32'h0000_0060, 1'b1, 1'b0, '0, 1);
        chk("wrap_data", rdata_s, {8{32'd3}});

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
